id_ex_operand_stage: RTL

ID/EX pipeline register and operand-forwarding stage of the pipelined MIPS core. It captures decoded instruction fields from ID and drives the ALU's `inputA`, `inputB` and `aluOperation` during EX. It resolves RAW hazards by forwarding from MEM and WB. It detects load-use hazards, inserts bubbles on those hazards and on flush, and holds its state on an external stall.

---
 rtl/id_ex_operand_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble
// insertion, flush-to-bubble and stall hold with forwarded-operand refresh.
module id_ex_operand_stage (
  input  logic        clk,
  input  logic        rstN,
  input  logic        stall,
  input  logic        flush,
  input  logic        idValid,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic [4:0]  idRd,
  input  logic [31:0] idRsData,
  input  logic [31:0] idRtData,
  input  logic [15:0] idImm,
  input  logic [3:0]  idAluOp,
  input  logic        idUseImm,
  input  logic        idDestRt,
  input  logic        idRegWrite,
  input  logic        idIsLoad,
  input  logic        memRegWrite,
  input  logic [4:0]  memDest,
  input  logic [31:0] memResult,
  input  logic        wbRegWrite,
  input  logic [4:0]  wbDest,
  input  logic [31:0] wbResult,
  output logic [31:0] inputA,
  output logic [31:0] inputB,
  output logic [3:0]  aluOperation,
  output logic [31:0] exStoreData,
  output logic        exValid,
  output logic        exRegWrite,
  output logic        exIsLoad,
  output logic [4:0]  exDest,
  output logic        loadUseStall
);

  logic        r_valid;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_dest;
  logic [31:0] r_rsData;
  logic [31:0] r_rtData;
  logic [31:0] r_imm32;
  logic [3:0]  r_aluOp;
  logic        r_useImm;
  logic        r_regWrite;
  logic        r_isLoad;

  logic [31:0] w_fwdA;
  logic [31:0] w_fwdB;
  logic [4:0]  w_idDest;
  logic        w_loadUse;

  // MEM is the younger result, so it wins over WB; register 0 never forwards.
  always_comb begin
    w_fwdA = r_rsData;
    if (memRegWrite && (memDest != 5'd0) && (memDest == r_rs))
      w_fwdA = memResult;
    else if (wbRegWrite && (wbDest != 5'd0) && (wbDest == r_rs))
      w_fwdA = wbResult;

    w_fwdB = r_rtData;
    if (memRegWrite && (memDest != 5'd0) && (memDest == r_rt))
      w_fwdB = memResult;
    else if (wbRegWrite && (wbDest != 5'd0) && (wbDest == r_rt))
      w_fwdB = wbResult;
  end

  assign w_idDest  = idDestRt ? idRt : idRd;
  assign w_loadUse = r_valid && r_isLoad && (r_dest != 5'd0) && idValid &&
                     ((r_dest == idRs) || (r_dest == idRt));

  assign inputA       = w_fwdA;
  assign inputB       = r_useImm ? r_imm32 : w_fwdB;
  assign exStoreData  = w_fwdB;
  assign aluOperation = r_aluOp;
  assign exValid      = r_valid;
  assign exRegWrite   = r_regWrite;
  assign exIsLoad     = r_isLoad;
  assign exDest       = r_dest;
  assign loadUseStall = w_loadUse;

  // Flush beats stall; a load-use hazard only bubbles when not stalled.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_valid    <= 1'b0;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_dest     <= 5'd0;
      r_rsData   <= 32'd0;
      r_rtData   <= 32'd0;
      r_imm32    <= 32'd0;
      r_aluOp    <= 4'd0;
      r_useImm   <= 1'b0;
      r_regWrite <= 1'b0;
      r_isLoad   <= 1'b0;
    end else if (flush || (!stall && w_loadUse)) begin
      r_valid    <= 1'b0;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_dest     <= 5'd0;
      r_rsData   <= 32'd0;
      r_rtData   <= 32'd0;
      r_imm32    <= 32'd0;
      r_aluOp    <= 4'd0;
      r_useImm   <= 1'b0;
      r_regWrite <= 1'b0;
      r_isLoad   <= 1'b0;
    end else if (stall) begin
      // Keep a WB value that retires during the hold.
      r_rsData <= w_fwdA;
      r_rtData <= w_fwdB;
    end else begin
      r_valid    <= idValid;
      r_rs       <= idRs;
      r_rt       <= idRt;
      r_dest     <= w_idDest;
      r_rsData   <= idRsData;
      r_rtData   <= idRtData;
      r_imm32    <= {{16{idImm[15]}}, idImm};
      r_aluOp    <= idAluOp;
      r_useImm   <= idUseImm;
      r_regWrite <= idRegWrite && idValid && (w_idDest != 5'd0);
      r_isLoad   <= idIsLoad;
    end
  end

endmodule
